// File: rtl/minterm_scanner.sv
// rtl/minterm_scanner.sv - clocked minterm sequencer that checks SoP/PoS outputs against a truth table
module minterm_scanner #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expect_mask,
  input  logic                 f_sop,
  input  logic                 f_pos,
  output logic [N_IN-1:0]      xyw,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        mism_cnt,
  output logic [N_IN-1:0]      first_bad,
  output logic [2**N_IN-1:0]   sop_table,
  output logic [2**N_IN-1:0]   pos_table
);

  localparam int NM = 2**N_IN;
  localparam logic [N_IN-1:0] XYW_MAX  = N_IN'(NM - 1);
  localparam logic [3:0]      CNT_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NM-1:0]     mask_q, mask_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [N_IN-1:0]   xyw_q, xyw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     mism_cnt_q, mism_cnt_d;
  logic [N_IN-1:0]   first_bad_q, first_bad_d;
  logic [NM-1:0]     sop_table_q, sop_table_d;
  logic [NM-1:0]     pos_table_q, pos_table_d;
  logic              bad;

  // A minterm is bad once, regardless of whether one or both outputs disagree.
  assign bad = (f_sop != mask_q[xyw_q]) | (f_pos != mask_q[xyw_q]);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    xyw_d       = xyw_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    mism_cnt_d  = mism_cnt_q;
    first_bad_d = first_bad_q;
    sop_table_d = sop_table_q;
    pos_table_d = pos_table_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d      = expect_mask;
          mism_cnt_d  = '0;
          first_bad_d = '0;
          pass_d      = 1'b0;
          sop_table_d = '0;
          pos_table_d = '0;
          xyw_d       = '0;
          cnt_d       = CNT_INIT;
          busy_d      = 1'b1;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          sop_table_d[xyw_q] = f_sop;
          pos_table_d[xyw_q] = f_pos;
          if (bad) begin
            mism_cnt_d = mism_cnt_q + 1'b1;
            if (mism_cnt_q == '0) begin
              first_bad_d = xyw_q;
            end
          end
          if (xyw_q == XYW_MAX) begin
            // pass is registered alongside done so both are valid in the same cycle.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mism_cnt_d == '0);
            state_d = S_DONE;
          end else begin
            xyw_d = xyw_q + 1'b1;
            cnt_d = CNT_INIT;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      xyw_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      mism_cnt_q  <= '0;
      first_bad_q <= '0;
      sop_table_q <= '0;
      pos_table_q <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      xyw_q       <= xyw_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      mism_cnt_q  <= mism_cnt_d;
      first_bad_q <= first_bad_d;
      sop_table_q <= sop_table_d;
      pos_table_q <= pos_table_d;
    end
  end

  assign xyw       = xyw_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign mism_cnt  = mism_cnt_q;
  assign first_bad = first_bad_q;
  assign sop_table = sop_table_q;
  assign pos_table = pos_table_q;

endmodule

// File: tb/tb_minterm_scanner.sv
// tb/tb_minterm_scanner.sv - directed self-checking bench for minterm_scanner
module tb_minterm_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start3;
  logic [7:0] expect_mask;
  logic [7:0] sop_func, pos_func;

  logic       f_sop, f_pos, f_sop3, f_pos3;
  logic [2:0] xyw, xyw3;
  logic       busy, busy3, done, done3, pass, pass3;
  logic [3:0] mism_cnt, mism_cnt3;
  logic [2:0] first_bad, first_bad3;
  logic [7:0] sop_table, sop_table3, pos_table, pos_table3;

  int n_cmp = 0;
  int n_bad = 0;
  int lat;

  always #5 clk = ~clk;

  // Behavioural stand-in for the SoP/PoS stage under test.
  assign f_sop  = sop_func[xyw];
  assign f_pos  = pos_func[xyw];
  assign f_sop3 = sop_func[xyw3];
  assign f_pos3 = pos_func[xyw3];

  minterm_scanner #(.N_IN(3), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .expect_mask(expect_mask),
    .f_sop(f_sop), .f_pos(f_pos), .xyw(xyw), .busy(busy), .done(done),
    .pass(pass), .mism_cnt(mism_cnt), .first_bad(first_bad),
    .sop_table(sop_table), .pos_table(pos_table)
  );

  minterm_scanner #(.N_IN(3), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .expect_mask(expect_mask),
    .f_sop(f_sop3), .f_pos(f_pos3), .xyw(xyw3), .busy(busy3), .done(done3),
    .pass(pass3), .mism_cnt(mism_cnt3), .first_bad(first_bad3),
    .sop_table(sop_table3), .pos_table(pos_table3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge, then counts cycles until done (bounded).
  task automatic run_scan(output int latency);
    start = 1'b1;
    tick();
    start = 1'b0;
    latency = 0;
    while (!done && latency < 100) begin
      tick();
      latency++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start3 = 1'b0;
    expect_mask = 8'h00; sop_func = 8'h00; pos_func = 8'h00;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_xyw", xyw, 0);
    check("rst_mism", mism_cnt, 0);
    check("rst_tables", {sop_table, pos_table}, 0);
    reset = 1'b0;
    tick();

    // 1: correct DUT
    expect_mask = 8'h35; sop_func = 8'h35; pos_func = 8'h35;
    run_scan(lat);
    check("s1_latency", lat, 8);
    check("s1_pass", pass, 1);
    check("s1_mism", mism_cnt, 0);
    check("s1_sop", sop_table, 8'h35);
    check("s1_pos", pos_table, 8'h35);
    check("s1_busy_at_done", busy, 0);
    tick();
    check("s1_done_pulse", done, 0);
    check("s1_pass_held", pass, 1);

    // 2: f_pos wrong at minterm 6
    pos_func = 8'h75;
    run_scan(lat);
    check("s2_latency", lat, 8);
    check("s2_mism", mism_cnt, 1);
    check("s2_first_bad", first_bad, 6);
    check("s2_pass", pass, 0);
    check("s2_pos", pos_table, 8'h75);
    check("s2_sop", sop_table, 8'h35);
    pos_func = 8'h35;
    tick();

    // 3: SETTLE=3 instance
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("s3_busy", busy3, 1);
    check("s3_xyw_e0", xyw3, 0);
    for (int c = 1; c <= 23; c++) begin
      tick();
      check($sformatf("s3_xyw_e%0d", c), xyw3, (c / 3 > 7) ? 7 : c / 3);
      check($sformatf("s3_nodone_e%0d", c), done3, 0);
    end
    tick();
    check("s3_done_e24", done3, 1);
    check("s3_pass", pass3, 1);
    check("s3_mism", mism_cnt3, 0);
    check("s3_sop", sop_table3, 8'h35);
    check("s3_pos", pos_table3, 8'h35);
    tick();
    check("s3_done_low", done3, 0);

    // 4: start re-pulsed mid-scan is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("s4_xyw3", xyw, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 4;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("s4_latency", lat, 8);
    check("s4_pass", pass, 1);
    check("s4_sop", sop_table, 8'h35);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s4_restart_busy", busy, 1);
    check("s4_restart_pass_clr", pass, 0);
    check("s4_restart_tables_clr", {sop_table, pos_table}, 0);
    check("s4_restart_xyw", xyw, 0);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("s4_rescan_latency", lat, 8);
    check("s4_rescan_pass", pass, 1);
    tick();

    // 5: reset mid-scan at minterm 4
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("s5_xyw4", xyw, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s5_busy", busy, 0);
    check("s5_xyw", xyw, 0);
    check("s5_results", {pass, mism_cnt, first_bad, sop_table, pos_table}, 0);
    lat = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done) lat++;
    end
    check("s5_no_done", lat, 0);
    run_scan(lat);
    check("s5_after_latency", lat, 8);
    check("s5_after_pass", pass, 1);
    tick();

    // 6: inverted mask, every minterm bad
    expect_mask = 8'hCA;
    run_scan(lat);
    check("s6_latency", lat, 8);
    check("s6_mism", mism_cnt, 8);
    check("s6_first_bad", first_bad, 0);
    check("s6_pass", pass, 0);
    check("s6_sop", sop_table, 8'h35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
